// File: rtl/operand_select_pipe.sv
// -----------------------------------------------------------------------------
// operand_select_pipe
//
// Parametrised N-way operand selector with a registered, back-pressurable
// output stage. One of NUM_IN packed candidate operands is picked by in_sel
// and delivered on out_* one cycle after the input transfer. A two-entry
// buffer (main output register + one skid register) lets in_ready be a pure
// register, so there is no combinational path from out_ready to in_ready.
//
// Select codes at or above NUM_IN never forward stale data: the beat carries
// zero with out_sel_err set, and a saturating counter records each such
// accepted beat.
//
// Ports
//   clk          in   1             clock, all state on rising edge
//   rst_n        in   1             asynchronous reset, active-low
//   in_data      in   NUM_IN*WIDTH  operand i at [i*WIDTH +: WIDTH]
//   in_sel       in   SEL_W         index of operand to forward
//   in_valid     in   1             in_data/in_sel valid this cycle
//   in_ready     out  1             block can accept this cycle
//   out_data     out  WIDTH         selected operand
//   out_sel_err  out  1             out_data came from an out-of-range select
//   out_valid    out  1             out_data/out_sel_err valid
//   out_ready    in   1             consumer accepts this cycle
//   err_count    out  CNT_W         accepted out-of-range selects (saturating)
//   err_clr      in   1             synchronous clear of err_count
//
// Parameters
//   WIDTH   bits per operand
//   NUM_IN  number of candidate operands (2..16)
//   SEL_W   select width, 2**SEL_W >= NUM_IN
//   CNT_W   width of the saturating select-error counter
// -----------------------------------------------------------------------------
module operand_select_pipe #(
  parameter int WIDTH  = 64,
  parameter int NUM_IN = 5,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        err_count,
  input  logic                    err_clr
);

  // Buffer occupancy. The encoding is {main_valid, skid_valid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } occ_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  occ_e             state;
  logic [WIDTH-1:0] main_data;
  logic             main_err;
  logic [WIDTH-1:0] skid_data;
  logic             skid_err;
  logic             ready_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic             main_valid;
  logic             in_xfer;
  logic             out_xfer;

  // ---------------------------------------------------------------------------
  // Operand selection. Out-of-range codes fall through to the defaults,
  // which is exactly the zero-with-error result.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaults assigned before the loop so every path drives both
    // outputs; without them this block would infer latches.
    sel_data = '0;
    sel_err  = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (in_sel == SEL_W'(i)) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  assign main_valid = (state != EMPTY);
  assign in_xfer    = in_valid & ready_q;
  assign out_xfer   = main_valid & out_ready;

  // ---------------------------------------------------------------------------
  // Occupancy FSM with the main output register and the registered ready.
  // ready_q equals ~skid_valid once out of reset; it is held low during reset
  // so nothing is accepted before the first edge after release.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values of its neighbours.
      state     <= EMPTY;
      main_data <= '0;
      main_err  <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      ready_q <= (state != FULL);
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_data <= sel_data;
            main_err  <= sel_err;
            state     <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            // Drain and refill in the same cycle.
            main_data <= sel_data;
            main_err  <= sel_err;
          end else if (in_xfer) begin
            // Consumer stalled: new beat parks in the skid register.
            state   <= FULL;
            ready_q <= 1'b0;
          end else if (out_xfer) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          // ready_q is low here, so no input transfer can coincide.
          if (out_xfer) begin
            main_data <= skid_data;
            main_err  <= skid_err;
            state     <= ONE;
            ready_q   <= 1'b1;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Skid register. Its contents are only ever read while state is FULL.
  // ---------------------------------------------------------------------------
  // NOTE: the skid data register has no reset; its contents are qualified by
  // the occupancy state, so resetting it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (state == ONE && in_xfer && !out_xfer) begin
      skid_data <= sel_data;
      skid_err  <= sel_err;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating select-error counter; clear wins over increment.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (err_clr) begin
      cnt_q <= '0;
    end else if (in_xfer && sel_err && cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign in_ready    = ready_q;
  assign out_valid   = main_valid;
  assign out_data    = main_data;
  assign out_sel_err = main_err;
  assign err_count   = cnt_q;

endmodule

// File: tb/tb_operand_select_pipe.sv
// -----------------------------------------------------------------------------
// tb_operand_select_pipe
//
// Three instances share clock and reset:
//   m_* : default parameters (64-bit, 5 inputs, 8-bit counter)
//   s_* : CNT_W=2 for counter saturation
//   z_* : WIDTH=32, NUM_IN=2, SEL_W=1 for the long random run
// The m_ and z_ instances are continuously compared, on every falling edge,
// against a reference that treats the block as a depth-2 FIFO of selected
// beats plus an integer error counter.
// -----------------------------------------------------------------------------
module tb_operand_select_pipe;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- default instance ----------------
  logic [5*64-1:0] m_in_data;
  logic [2:0]      m_in_sel;
  logic            m_in_valid, m_in_ready, m_out_sel_err, m_out_valid, m_out_ready, m_err_clr;
  logic [63:0]     m_out_data;
  logic [7:0]      m_err_count;

  operand_select_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_data(m_in_data), .in_sel(m_in_sel),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .out_data(m_out_data),
    .out_sel_err(m_out_sel_err), .out_valid(m_out_valid), .out_ready(m_out_ready),
    .err_count(m_err_count), .err_clr(m_err_clr)
  );

  // ---------------- saturation instance ----------------
  logic [5*64-1:0] s_in_data;
  logic [2:0]      s_in_sel;
  logic            s_in_valid, s_in_ready, s_out_sel_err, s_out_valid, s_out_ready, s_err_clr;
  logic [63:0]     s_out_data;
  logic [1:0]      s_err_count;

  operand_select_pipe #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_data(s_in_data), .in_sel(s_in_sel),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .out_data(s_out_data),
    .out_sel_err(s_out_sel_err), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .err_count(s_err_count), .err_clr(s_err_clr)
  );

  // ---------------- small instance ----------------
  logic [2*32-1:0] z_in_data;
  logic            z_in_sel;
  logic            z_in_valid, z_in_ready, z_out_sel_err, z_out_valid, z_out_ready, z_err_clr;
  logic [31:0]     z_out_data;
  logic [7:0]      z_err_count;

  operand_select_pipe #(.WIDTH(32), .NUM_IN(2), .SEL_W(1)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_data(z_in_data), .in_sel(z_in_sel),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .out_data(z_out_data),
    .out_sel_err(z_out_sel_err), .out_valid(z_out_valid), .out_ready(z_out_ready),
    .err_count(z_err_count), .err_clr(z_err_clr)
  );

  // Set once a rising edge has occurred since reset was released.
  bit armed = 1'b0;
  always @(posedge clk or negedge rst_n) armed = rst_n;

  // ---------------- reference models ----------------
  beat_t m_q[$];
  int    m_cnt = 0;
  beat_t z_q[$];
  int    z_cnt = 0;

  always @(negedge clk) begin
    beat_t b;
    bit    rdy;
    int    s;
    if (!rst_n) begin
      m_q.delete();
      m_cnt = 0;
    end else begin
      rdy = armed && (m_q.size() < 2);
      check("m_in_ready", m_in_ready, rdy);
      check("m_out_valid", m_out_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        check("m_out_data", m_out_data, m_q[0].data);
        check("m_out_sel_err", m_out_sel_err, m_q[0].err);
      end
      check("m_err_count", m_err_count, m_cnt);
      // Advance to the state after the coming rising edge.
      if (m_q.size() != 0 && m_out_ready) void'(m_q.pop_front());
      if (m_in_valid && rdy) begin
        s = int'(m_in_sel);
        b.err  = (s >= 5);
        b.data = b.err ? 64'd0 : m_in_data[s*64 +: 64];
        m_q.push_back(b);
        if (b.err && m_cnt < 255) m_cnt++;
      end
      if (m_err_clr) m_cnt = 0;
    end
  end

  always @(negedge clk) begin
    beat_t b;
    bit    rdy;
    if (!rst_n) begin
      z_q.delete();
      z_cnt = 0;
    end else begin
      rdy = armed && (z_q.size() < 2);
      check("z_in_ready", z_in_ready, rdy);
      check("z_out_valid", z_out_valid, z_q.size() != 0);
      if (z_q.size() != 0) begin
        check("z_out_data", z_out_data, z_q[0].data);
        check("z_out_sel_err", z_out_sel_err, z_q[0].err);
      end
      check("z_err_count", z_err_count, z_cnt);
      if (z_q.size() != 0 && z_out_ready) void'(z_q.pop_front());
      if (z_in_valid && rdy) begin
        b.err  = 1'b0;
        b.data = 64'(z_in_data[(z_in_sel ? 32 : 0) +: 32]);
        z_q.push_back(b);
      end
      if (z_err_clr) z_cnt = 0;
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [63:0] op(input int i);
    return 64'h1111_0000 + 64'(i);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_in_valid = 0; m_in_sel = 0; m_out_ready = 0; m_err_clr = 0;
    s_in_valid = 0; s_in_sel = 0; s_out_ready = 1; s_err_clr = 0; s_in_data = '0;
    z_in_valid = 0; z_in_sel = 0; z_out_ready = 0; z_err_clr = 0; z_in_data = '0;
    for (int i = 0; i < 5; i++) m_in_data[i*64 +: 64] = op(i);

    // Reset state, no clock edge yet.
    #1;
    check("rst_out_valid", m_out_valid, 1'b0);
    check("rst_out_data", m_out_data, 64'd0);
    check("rst_out_sel_err", m_out_sel_err, 1'b0);
    check("rst_err_count", m_err_count, 8'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    next_cycle();
    check("ready_after_release", m_in_ready, 1'b1);

    // Stream sel 0..4 back to back with the consumer always ready.
    m_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      m_in_valid = 1'b1;
      m_in_sel   = 3'(i);
      @(negedge clk);
      if (i > 0) begin
        check("stream_valid", m_out_valid, 1'b1);
        check("stream_data", m_out_data, op(i - 1));
      end
      next_cycle();
    end
    m_in_valid = 1'b0;
    @(negedge clk);
    check("stream_valid", m_out_valid, 1'b1);
    check("stream_data", m_out_data, op(4));
    next_cycle();

    // Back-pressure: three beats offered while the consumer is stalled.
    m_out_ready = 1'b0;
    m_in_valid  = 1'b1;
    m_in_sel    = 3'd1;
    next_cycle();
    m_in_sel = 3'd2;
    @(negedge clk);
    check("bp_first_out", m_out_data, op(1));
    next_cycle();
    m_in_sel = 3'd3;
    repeat (3) begin
      @(negedge clk);
      check("bp_ready_low", m_in_ready, 1'b0);
      check("bp_stable", m_out_data, op(1));
      next_cycle();
    end
    m_out_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    check("bp_second_out", m_out_data, op(2));
    check("bp_ready_back", m_in_ready, 1'b1);
    next_cycle();
    m_in_valid = 1'b0;
    @(negedge clk);
    check("bp_third_out", m_out_data, op(3));
    next_cycle();

    // Illegal selects 5, 6, 7.
    for (int i = 5; i < 8; i++) begin
      m_in_valid = 1'b1;
      m_in_sel   = 3'(i);
      next_cycle();
      m_in_valid = 1'b0;
      @(negedge clk);
      check("ill_data", m_out_data, 64'd0);
      check("ill_flag", m_out_sel_err, 1'b1);
    end
    next_cycle();
    check("ill_count", m_err_count, 8'd3);

    // Reset mid-stream: fill the buffer, then assert reset between edges.
    m_out_ready = 1'b0;
    m_in_valid  = 1'b1;
    m_in_sel    = 3'd2;
    next_cycle();
    next_cycle();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", m_out_valid, 1'b0);
    check("midrst_err_count", m_err_count, 8'd0);
    check("midrst_in_ready", m_in_ready, 1'b0);
    m_in_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    next_cycle();

    // Saturation on the 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      s_in_valid = 1'b1;
      s_in_sel   = 3'(5 + (i % 3));
      next_cycle();
    end
    s_in_valid = 1'b0;
    @(negedge clk);
    check("sat_count", s_err_count, 2'd3);
    check("sat_flag", s_out_sel_err, 1'b1);
    next_cycle();
    s_in_valid = 1'b1;
    s_in_sel   = 3'd7;
    s_err_clr  = 1'b1;
    next_cycle();
    s_err_clr = 1'b0;
    @(negedge clk);
    check("sat_clr_priority", s_err_count, 2'd0);
    next_cycle();
    s_in_valid = 1'b0;
    @(negedge clk);
    check("sat_after_clr", s_err_count, 2'd1);

    // Random valid/ready on the default and the small instance.
    for (int c = 0; c < 10000; c++) begin
      next_cycle();
      m_in_valid  = ($urandom_range(0, 3) != 0);
      m_out_ready = ($urandom_range(0, 2) != 0);
      m_in_sel    = 3'($urandom_range(0, 7));
      m_err_clr   = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < 5; i++) m_in_data[i*64 +: 64] = {$urandom, $urandom};
      z_in_valid  = $urandom_range(0, 1) != 0;
      z_out_ready = $urandom_range(0, 1) != 0;
      z_in_sel    = 1'($urandom_range(0, 1));
      z_in_data   = {$urandom, $urandom};
    end
    next_cycle();
    m_in_valid = 1'b0; m_out_ready = 1'b1; m_err_clr = 1'b0;
    z_in_valid = 1'b0; z_out_ready = 1'b1;
    repeat (4) next_cycle();
    @(negedge clk);
    check("drain_m_empty", m_out_valid, 1'b0);
    check("drain_z_empty", z_out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
